// File: rtl/axi_arbiter_m2s_m3.sv
// Round-robin arbiter for one slave port: AW/W path and AR path, each granting one master at a time.
// Write grant is held until both the address and the last data beat have completed.
module axi_arbiter_m2s_m3 #(
    parameter int NUM = 3
) (
    input  logic         AXI_CLK,
    input  logic         AXI_RST,
    input  logic [NUM:0] AWSELECT,
    input  logic [NUM:0] AWVALID,
    input  logic [NUM:0] AWREADY,
    output logic [NUM:0] AWGRANT,
    input  logic [NUM:0] WVALID,
    input  logic [NUM:0] WREADY,
    input  logic [NUM:0] WLAST,
    output logic [NUM:0] WGRANT,
    input  logic [NUM:0] ARSELECT,
    input  logic [NUM:0] ARVALID,
    input  logic [NUM:0] ARREADY,
    output logic [NUM:0] ARGRANT
);

    localparam int N     = NUM + 1;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;

    // First requester at or above ptr, wrapping from NUM back to 0.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM:0] req, input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] cand;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM)) ? '0 : idx + PTR_W'(1);
    endfunction

    function automatic logic [NUM:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    w_state_t         w_state_reg, w_state_next;
    r_state_t         r_state_reg, r_state_next;
    logic [NUM:0]     wgnt_reg, wgnt_next, rgnt_reg, rgnt_next;
    logic             aw_done_reg, aw_done_next, w_done_reg, w_done_next;
    logic [PTR_W-1:0] wptr_reg, wptr_next, rptr_reg, rptr_next;
    logic [NUM:0]     wreq, rreq, aw_hit, w_hit, ar_hit;
    logic [PTR_W-1:0] w_pick, r_pick;
    logic             aw_event, w_event, ar_event;

    assign wreq   = AWSELECT & AWVALID;
    assign rreq   = ARSELECT & ARVALID;
    assign w_pick = rr_pick(wreq, wptr_reg);
    assign r_pick = rr_pick(rreq, rptr_reg);

    // Grants come straight from registered state, so request-to-grant is one cycle.
    assign AWGRANT = (w_state_reg == W_BUSY && !aw_done_reg) ? wgnt_reg : '0;
    assign WGRANT  = (w_state_reg == W_BUSY && !w_done_reg)  ? wgnt_reg : '0;
    assign ARGRANT = (r_state_reg == R_BUSY) ? rgnt_reg : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign aw_hit[gi] = AWGRANT[gi] & AWVALID[gi] & AWREADY[gi];
        assign w_hit[gi]  = WGRANT[gi] & WVALID[gi] & WREADY[gi] & WLAST[gi];
        assign ar_hit[gi] = ARGRANT[gi] & ARVALID[gi] & ARREADY[gi];
    end

    assign aw_event = |aw_hit;
    assign w_event  = |w_hit;
    assign ar_event = |ar_hit;

    always_comb begin
        w_state_next = w_state_reg;
        wgnt_next    = wgnt_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        wptr_next    = wptr_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (|wreq) begin
                    wgnt_next    = onehot(w_pick);
                    wptr_next    = ptr_after(w_pick);
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    w_state_next = W_BUSY;
                end
            end
            default: begin
                aw_done_next = aw_done_reg | aw_event;
                w_done_next  = w_done_reg | w_event;
                if (aw_done_next && w_done_next) begin
                    w_state_next = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        rgnt_next    = rgnt_reg;
        rptr_next    = rptr_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (|rreq) begin
                    rgnt_next    = onehot(r_pick);
                    rptr_next    = ptr_after(r_pick);
                    r_state_next = R_BUSY;
                end
            end
            default: begin
                if (ar_event) begin
                    r_state_next = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            w_state_reg <= W_IDLE;
            r_state_reg <= R_IDLE;
            wgnt_reg    <= '0;
            rgnt_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wptr_reg    <= '0;
            rptr_reg    <= '0;
        end else begin
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
            wgnt_reg    <= wgnt_next;
            rgnt_reg    <= rgnt_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
        end
    end

endmodule

// File: tb/tb_axi_arbiter_m2s_m3.sv
// Directed bench for axi_arbiter_m2s_m3: each cycle inputs are driven 2 ns after the rising edge
// and the grants of that cycle are compared against hand-computed vectors.
module tb_axi_arbiter_m2s_m3;

    localparam int NUM = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [NUM:0] awsel, awvalid, awready, awgrant;
    logic [NUM:0] wvalid, wready, wlast, wgrant;
    logic [NUM:0] arsel, arvalid, arready, argrant;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    axi_arbiter_m2s_m3 #(.NUM(NUM)) dut (
        .AXI_CLK  (clk),
        .AXI_RST  (rst),
        .AWSELECT (awsel),
        .AWVALID  (awvalid),
        .AWREADY  (awready),
        .AWGRANT  (awgrant),
        .WVALID   (wvalid),
        .WREADY   (wready),
        .WLAST    (wlast),
        .WGRANT   (wgrant),
        .ARSELECT (arsel),
        .ARVALID  (arvalid),
        .ARREADY  (arready),
        .ARGRANT  (argrant)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs[NUM:0], exp[NUM:0]);
        end else begin
            $display("ok   %s = %b", tag, obs[NUM:0]);
        end
    endtask

    task automatic check_grants(input string tag, input int c,
                                input logic [NUM:0] exp_aw, input logic [NUM:0] exp_w,
                                input logic [NUM:0] exp_ar);
        check_eq($sformatf("%s c%0d awgrant", tag, c), 32'(awgrant), 32'(exp_aw));
        check_eq($sformatf("%s c%0d wgrant", tag, c), 32'(wgrant), 32'(exp_w));
        check_eq($sformatf("%s c%0d argrant", tag, c), 32'(argrant), 32'(exp_ar));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        awsel = '0; awvalid = '0; awready = '0;
        wvalid = '0; wready = '0; wlast = '0;
        arsel = '0; arvalid = '0; arready = '0;
    endtask

    // Leaves the bench in cycle 0 of the next test with reset low and all grants idle.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        check_grants({tag, " reset"}, 0, 4'b0000, 4'b0000, 4'b0000);
    endtask

    initial begin
        logic [NUM:0] cont_exp [8];
        cont_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        clear_inputs();

        // Single 4-beat write from master 1
        do_reset("single");
        awsel = 4'b0010; awvalid = 4'b0010;
        tick();
        check_grants("single", 1, 4'b0010, 4'b0010, 4'b0000);
        tick();
        awready = 4'b1111; wvalid = 4'b0010; wready = 4'b1111;
        check_grants("single", 2, 4'b0010, 4'b0010, 4'b0000);
        for (int c = 3; c <= 5; c++) begin
            tick();
            awvalid = 4'b0000; awready = 4'b0000;
            wlast = (c == 5) ? 4'b0010 : 4'b0000;
            check_grants("single", c, 4'b0000, 4'b0010, 4'b0000);
        end
        tick();
        clear_inputs();
        awsel = 4'b0100; awvalid = 4'b0100;
        check_grants("single", 6, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_grants("single idle-check", 7, 4'b0100, 4'b0100, 4'b0000);
        $display("test single write done");

        // Contention among masters 0, 2, 3 with single-beat writes
        do_reset("contend");
        awsel = 4'b1101; awvalid = 4'b1101; awready = 4'b1111;
        wvalid = 4'b1101; wready = 4'b1111; wlast = 4'b1101;
        for (int c = 1; c < 8; c++) begin
            tick();
            check_grants("contend", c, cont_exp[c], cont_exp[c], 4'b0000);
        end
        $display("test write contention done");

        // W completes before AW on master 2
        do_reset("wfirst");
        awsel = 4'b0100; awvalid = 4'b0100;
        tick();
        wvalid = 4'b0100; wready = 4'b1111; wlast = 4'b0100;
        check_grants("wfirst", 1, 4'b0100, 4'b0100, 4'b0000);
        for (int c = 2; c <= 4; c++) begin
            tick();
            wvalid = '0; wlast = '0;
            awready = (c == 4) ? 4'b1111 : 4'b0000;
            check_grants("wfirst", c, 4'b0100, 4'b0000, 4'b0000);
        end
        tick();
        clear_inputs();
        awsel = 4'b0010; awvalid = 4'b0010;
        check_grants("wfirst", 5, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_grants("wfirst idle-check", 6, 4'b0010, 4'b0010, 4'b0000);
        $display("test W before AW done");

        // Concurrent write (master 0, 2 beats) and reads from masters 1 and 3
        do_reset("concur");
        awsel = 4'b0001; awvalid = 4'b0001;
        arsel = 4'b1010; arvalid = 4'b1010; arready = 4'b1111;
        tick();
        awready = 4'b1111; wvalid = 4'b0001; wready = 4'b1111;
        check_grants("concur", 1, 4'b0001, 4'b0001, 4'b0010);
        tick();
        awvalid = '0; awready = '0; wlast = 4'b0001;
        arsel = 4'b1000; arvalid = 4'b1000;
        check_grants("concur", 2, 4'b0000, 4'b0001, 4'b0000);
        tick();
        wvalid = '0; wlast = '0;
        check_grants("concur", 3, 4'b0000, 4'b0000, 4'b1000);
        tick();
        arsel = '0; arvalid = '0;
        check_grants("concur", 4, 4'b0000, 4'b0000, 4'b0000);
        $display("test concurrent read/write done");

        // Reset in the middle of master 3's burst, with the read pointer left non-zero
        do_reset("midrst");
        awsel = 4'b1000; awvalid = 4'b1000;
        arsel = 4'b0010; arvalid = 4'b0010; arready = 4'b1111;
        tick();
        awready = 4'b1111; wvalid = 4'b1000; wready = 4'b1111;
        check_grants("midrst", 1, 4'b1000, 4'b1000, 4'b0010);
        tick();
        awvalid = '0; awready = '0; arsel = '0; arvalid = '0;
        check_grants("midrst", 2, 4'b0000, 4'b1000, 4'b0000);
        tick();
        rst = 1'b1;
        check_grants("midrst", 3, 4'b0000, 4'b1000, 4'b0000);
        tick();
        rst = 1'b0;
        clear_inputs();
        awsel = 4'b1001; awvalid = 4'b1001;
        arsel = 4'b0101; arvalid = 4'b0101;
        check_grants("midrst after", 4, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_grants("midrst after", 5, 4'b0001, 4'b0001, 4'b0001);
        $display("test reset mid-burst done");

        // AR pointer wrap from master 3 back to master 0
        do_reset("wrap");
        arsel = 4'b1000; arvalid = 4'b1000; arready = 4'b1111;
        tick();
        check_grants("wrap", 1, 4'b0000, 4'b0000, 4'b1000);
        tick();
        arsel = 4'b1001; arvalid = 4'b1001;
        check_grants("wrap", 2, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_grants("wrap", 3, 4'b0000, 4'b0000, 4'b0001);
        tick();
        check_grants("wrap", 4, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_grants("wrap", 5, 4'b0000, 4'b0000, 4'b1000);
        $display("test pointer wrap done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_m2s_m3.md
Name: axi_arbiter_m2s_m3

Overview:
- Master-to-slave channel arbiter for one slave port of the AXI interconnect. Companion to the slave-to-master R/B arbiter.
- Arbitrates NUM+1 masters onto the slave's AW/W path and, independently, its AR path, using round-robin.
- The write grant is held from the AW request until both the AW handshake and the last W beat have completed. This keeps write data from different masters from interleaving.
- The read grant is held until the AR handshake completes.

Parameters:
NUM, 3, index of highest master; bus width NUM+1 (default 4 masters)

Ports:
AXI_CLK  input  1  interface clock; all logic on rising edge
AXI_RST  input  1  synchronous, active-high reset
AWSELECT  input  NUM+1  per-master: AW address decodes to this slave
AWVALID  input  NUM+1  per-master AWVALID
AWREADY  input  NUM+1  slave AWREADY as seen on each master lane
AWGRANT  output  NUM+1  one-hot: master owning AW channel
WVALID  input  NUM+1  per-master WVALID
WREADY  input  NUM+1  slave WREADY per lane
WLAST  input  NUM+1  per-master WLAST
WGRANT  output  NUM+1  one-hot: master owning W channel
ARSELECT  input  NUM+1  per-master: AR address decodes to this slave
ARVALID  input  NUM+1  per-master ARVALID
ARREADY  input  NUM+1  slave ARREADY per lane
ARGRANT  output  NUM+1  one-hot: master owning AR channel

Behaviour:
- Reset (AXI_RST=1 at an edge, any state):
  - AWGRANT, WGRANT and ARGRANT are 0 from the next cycle.
  - Both FSMs go to IDLE.
  - Both round-robin pointers go to 0, so master 0 has highest priority.
  - aw_done and w_done are cleared.
- Requests: wreq = AWSELECT & AWVALID; rreq = ARSELECT & ARVALID.
- Round-robin arbiter, one per path:
  - Winner is the first set bit of the request vector, searching from the pointer upward and wrapping from NUM to 0.
  - When a grant is latched, pointer <= (winner+1) mod (NUM+1).
  - Requests are ignored while the path is busy.
- Write FSM, states W_IDLE and W_BUSY; grant register wgnt, aw_done and w_done flags.
  - W_IDLE:
    - If |wreq: wgnt <= winner; aw_done <= 0; w_done <= 0; go to W_BUSY.
    - Otherwise stay.
    - AWGRANT = WGRANT = 0.
  - W_BUSY, grant outputs:
    - AWGRANT = wgnt while !aw_done, else 0.
    - WGRANT = wgnt while !w_done, else 0. Write data may precede the address.
  - W_BUSY, completion events:
    - AW done: |(AWGRANT & AWVALID & AWREADY) sets aw_done.
    - W done: |(WGRANT & WVALID & WREADY & WLAST) sets w_done.
    - Non-last W beats change no state.
  - Exit W_BUSY to W_IDLE in the cycle where both are complete, counting registered flags OR same-cycle events. This includes AW and the last W landing together, e.g. a single-beat write.
  - Return to W_IDLE always costs one idle cycle before the next grant.
- Read FSM, states R_IDLE and R_BUSY; grant register rgnt.
  - R_IDLE: if |rreq, rgnt <= winner and go to R_BUSY. ARGRANT = 0.
  - R_BUSY: ARGRANT = rgnt. On |(ARGRANT & ARVALID & ARREADY), go to R_IDLE.
- Latency: request to grant is 1 cycle (grants are driven from registered state). Grant deasserts the cycle after the completing handshake.
- The read and write paths are fully independent and may both be busy at once.
- Grants are always one-hot or zero.
- A granted master dropping its VALID is not an error. The grant is held until completion; there is no timeout.
- A master in the grant vector with SELECT low after the grant keeps its grant. SELECT is sampled only in IDLE.

Test Plan:
- Single write:
  - Stimulus: master 1 AWVALID+AWSELECT at cycle 0; AWREADY at cycle 2; 4 W beats with WREADY=1 at cycles 2-5, WLAST on beat 4.
  - Required: AWGRANT=4'b0010 in cycles 1-2 only; WGRANT=4'b0010 in cycles 1-5; both grants 0 at cycle 6; FSM IDLE at cycle 6.
- Write contention:
  - Stimulus: masters 0, 2 and 3 request continuously; each slave completes a single-beat write in the first busy cycle.
  - Required: grant order 0, 2, 3, 0 with a gap of exactly one idle cycle between grants.
- W before AW:
  - Stimulus: master 2 granted; last W beat accepted at cycle 1; AWREADY withheld until cycle 4.
  - Required: WGRANT=0 from cycle 2; AWGRANT=4'b0100 through cycle 4; IDLE at cycle 5.
- Concurrent read and write:
  - Stimulus: master 0 writes a 2-beat burst while masters 1 and 3 issue AR back-to-back, each accepted on its first cycle.
  - Required: ARGRANT sequence 4'b0010, 4'b0000, 4'b1000, independent of write progress; write grants unaffected.
- Reset mid-burst:
  - Stimulus: master 3 in W_BUSY after 2 of 4 beats; AXI_RST=1 for one cycle; then masters 0 and 3 request.
  - Required: all grants 0 the cycle after reset; next write grant goes to master 0 (pointer reset).
- Pointer wrap:
  - Stimulus: master 3 wins AR; then masters 0 and 3 request AR.
  - Required: master 0 is granted first (wrap from 3 to 0), then master 3.
